// File: rtl/tpsr_stream_fifo.sv
// tpsr_stream_fifo: valid/ready FIFO front-end owning both ports of an external TPSR
// register file; the one-cycle registered read is absorbed by a 3-entry output skid buffer.
module tpsr_stream_fifo #(
   parameter int WORD_DEPTH = 16,
   parameter int DATA_WIDTH = 128,
   localparam int ADDR_WIDTH = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1,
   localparam int CNT_WIDTH  = $clog2(WORD_DEPTH + 4)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  S_VALID,
   output logic                  S_READY,
   input  logic [DATA_WIDTH-1:0] S_DATA,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic [CNT_WIDTH-1:0]  COUNT,
   output logic                  CENB,
   output logic [ADDR_WIDTH-1:0] AB,
   output logic [DATA_WIDTH-1:0] DB,
   output logic                  CENA,
   output logic [ADDR_WIDTH-1:0] AA,
   input  logic [DATA_WIDTH-1:0] QA
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(WORD_DEPTH);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_mem_cnt;
   logic                  r_rv;
   logic [1:0]            r_sk_cnt;
   logic [DATA_WIDTH-1:0] r_sk [3];

   logic       w_wr;
   logic       w_issue;
   logic       w_pop;
   logic       w_push;
   logic [2:0] w_credit;
   logic [1:0] w_push_idx;

   function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] ptr);
      return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
   endfunction

   always_comb begin
      S_READY    = !RST && (r_mem_cnt < FULL_CNT);
      M_VALID    = !RST && (r_sk_cnt != 2'd0);
      M_DATA     = r_sk[0];
      w_wr       = S_VALID && S_READY;
      w_pop      = M_VALID && M_READY;
      w_push     = !RST && r_rv;
      // r_rv marks QA carrying data this cycle; skid + in-flight may never exceed 3
      w_credit   = 3'(r_sk_cnt) + 3'(r_rv) - 3'(w_pop);
      w_issue    = !RST && (r_mem_cnt != '0) && (w_credit < 3'd3);
      w_push_idx = r_sk_cnt - 2'(w_pop);
      CENB       = !w_wr;
      AB         = r_wr_ptr;
      DB         = S_DATA;
      CENA       = !w_issue;
      AA         = r_rd_ptr;
      COUNT      = RST ? '0 : r_mem_cnt + CNT_WIDTH'(r_rv) + CNT_WIDTH'(r_sk_cnt);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_mem_cnt <= '0;
         r_rv      <= 1'b0;
         r_sk_cnt  <= '0;
      end else begin
         if (w_wr)    r_wr_ptr <= f_next(r_wr_ptr);
         if (w_issue) r_rd_ptr <= f_next(r_rd_ptr);
         r_rv <= w_issue;
         case ({w_wr, w_issue})
            2'b10:   r_mem_cnt <= r_mem_cnt + CNT_WIDTH'(1);
            2'b01:   r_mem_cnt <= r_mem_cnt - CNT_WIDTH'(1);
            default: r_mem_cnt <= r_mem_cnt;
         endcase
         r_sk_cnt <= r_sk_cnt + 2'(w_push) - 2'(w_pop);
      end
   end

   // Head-at-0 shift buffer; a simultaneous push lands one slot lower and wins.
   always_ff @(posedge CLK) begin
      if (w_pop) begin
         r_sk[0] <= r_sk[1];
         r_sk[1] <= r_sk[2];
      end
      if (w_push && (w_push_idx == 2'd0)) r_sk[0] <= QA;
      if (w_push && (w_push_idx == 2'd1)) r_sk[1] <= QA;
      if (w_push && (w_push_idx == 2'd2)) r_sk[2] <= QA;
   end

endmodule

// File: tb/tb_tpsr_stream_fifo.sv
// Directed self-checking bench for tpsr_stream_fifo with behavioural TPSR models,
// depth 8 (main instance) and depth 5 (wrap/full instance).
module tb_tpsr_stream_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, m_ready;
   logic [7:0] s_data;
   logic       s_ready, m_valid, cenb, cena;
   logic [7:0] m_data, db, qa;
   logic [3:0] count;
   logic [2:0] ab, aa;
   logic [7:0] mem8 [8];

   logic       s_valid5, m_ready5;
   logic [7:0] s_data5;
   logic       s_ready5, m_valid5, cenb5, cena5;
   logic [7:0] m_data5, db5, qa5;
   logic [3:0] count5;
   logic [2:0] ab5, aa5;
   logic [7:0] mem5 [5];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [7:0] sbq [$];
   int         wp = 0;
   int         rp = 0;

   always #5 clk = ~clk;

   tpsr_stream_fifo #(.WORD_DEPTH(8), .DATA_WIDTH(8)) u_dut (
      .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data), .COUNT(count),
      .CENB(cenb), .AB(ab), .DB(db), .CENA(cena), .AA(aa), .QA(qa)
   );

   tpsr_stream_fifo #(.WORD_DEPTH(5), .DATA_WIDTH(8)) u_dut5 (
      .CLK(clk), .RST(rst), .S_VALID(s_valid5), .S_READY(s_ready5), .S_DATA(s_data5),
      .M_VALID(m_valid5), .M_READY(m_ready5), .M_DATA(m_data5), .COUNT(count5),
      .CENB(cenb5), .AB(ab5), .DB(db5), .CENA(cena5), .AA(aa5), .QA(qa5)
   );

   always @(posedge clk) begin
      if (!cenb) mem8[ab] <= db;
      if (!cena) qa <= mem8[aa];
      if (!cenb5) mem5[ab5] <= db5;
      if (!cena5) qa5 <= mem5[aa5];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for the depth-8 instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         wp = 0;
         rp = 0;
      end else begin
         chk("COUNT_sb", 32'(count), 32'(sbq.size()));
         chk("CENB_hs", 32'(cenb), 32'(!(s_valid && s_ready)));
         if (!cenb) begin
            chk("AB_seq", 32'(ab), 32'(wp));
            sbq.push_back(s_data);
            wp = (wp == 7) ? 0 : wp + 1;
         end
         if (!cena) begin
            chk("AA_seq", 32'(aa), 32'(rp));
            rp = (rp == 7) ? 0 : rp + 1;
         end
         if (m_valid && m_ready) begin
            if (sbq.size() == 0) chk("pop_nonempty", 32'(sbq.size()), 32'd1);
            else chk("M_DATA_sb", 32'(m_data), 32'(sbq.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, got, sent, rcvd, first, last, npop, rdn;
      bit found;
      rst = 1'b1;
      s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      s_valid5 = 1'b0; m_ready5 = 1'b0; s_data5 = '0;
      step(); step();
      #2;
      chk("rst_M_VALID", 32'(m_valid), 32'd0);
      chk("rst_S_READY", 32'(s_ready), 32'd0);
      chk("rst_CENA", 32'(cena), 32'd1);
      chk("rst_CENB", 32'(cenb), 32'd1);
      chk("rst_COUNT", 32'(count), 32'd0);
      step();
      rst = 1'b0;

      // single word latency
      s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
      #2;
      chk("t0_S_READY", 32'(s_ready), 32'd1);
      chk("t0_CENB", 32'(cenb), 32'd0);
      chk("t0_AB", 32'(ab), 32'd0);
      step();
      s_valid = 1'b0;
      #2;
      chk("t1_CENA", 32'(cena), 32'd0);
      chk("t1_AA", 32'(aa), 32'd0);
      chk("t1_M_VALID", 32'(m_valid), 32'd0);
      chk("t1_COUNT", 32'(count), 32'd1);
      step();
      #2;
      chk("t2_M_VALID", 32'(m_valid), 32'd0);
      step();
      #2;
      chk("t3_M_VALID", 32'(m_valid), 32'd1);
      chk("t3_M_DATA", 32'(m_data), 32'hA5);
      step();
      #2;
      chk("t4_COUNT", 32'(count), 32'd0);
      chk("t4_M_VALID", 32'(m_valid), 32'd0);
      step();

      // fill with downstream stalled
      m_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 14; i++) begin
         s_valid = 1'b1; s_data = 8'(acc);
         #2;
         if (s_ready) acc++;
         step();
      end
      s_valid = 1'b0;
      step(); step();
      #2;
      chk("fill_accepted", 32'(acc), 32'd11);
      chk("fill_COUNT", 32'(count), 32'd11);
      chk("fill_S_READY", 32'(s_ready), 32'd0);
      chk("fill_head", 32'(m_data), 32'd0);
      step();
      m_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (m_valid) begin
            chk("drain_data", 32'(m_data), 32'(got));
            got++;
         end
         step();
      end
      chk("drain_words", 32'(got), 32'd11);
      chk("drain_COUNT", 32'(count), 32'd0);

      // continuous streaming, one word per cycle
      sent = 0; npop = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         s_valid = (sent < 40); s_data = 8'(sent);
         #2;
         if (s_valid && s_ready) sent++;
         if (m_valid && m_ready) begin
            if (first < 0) first = cyc;
            last = cyc;
            npop++;
         end
         step();
      end
      chk("stream_first", 32'(first), 32'd3);
      chk("stream_last", 32'(last), 32'd42);
      chk("stream_pops", 32'(npop), 32'd40);

      // random handshakes
      sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < 20000 && rcvd < 2000; cyc++) begin
         s_valid = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
         m_ready = 1'($urandom_range(0, 1));
         s_data = 8'(sent);
         #2;
         if (s_valid && s_ready) sent++;
         if (m_valid && m_ready) rcvd++;
         step();
      end
      chk("random_rcvd", 32'(rcvd), 32'd2000);
      s_valid = 1'b0; m_ready = 1'b0;
      step();

      // reset with words held and a read in flight
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_data = 8'(8'h10 + i);
         step();
      end
      s_valid = 1'b0;
      step(); step(); step();
      m_ready = 1'b1;
      #2;
      chk("pre_rst_COUNT", 32'(count), 32'd7);
      chk("pre_rst_head", 32'(m_data), 32'h10);
      chk("pre_rst_issue", 32'(cena), 32'd0);
      step();
      m_ready = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      chk("post_rst_M_VALID", 32'(m_valid), 32'd0);
      chk("post_rst_COUNT", 32'(count), 32'd0);
      chk("post_rst_S_READY", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
      step();
      s_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         #2;
         if (m_valid) begin
            chk("post_rst_first", 32'(m_data), 32'h3C);
            found = 1'b1;
         end
         step();
      end
      chk("post_rst_delivered", 32'(found), 32'd1);

      // depth 5: wrap and full point
      m_ready5 = 1'b0;
      acc = 0; rdn = 0;
      for (int i = 0; i < 12; i++) begin
         s_valid5 = 1'b1; s_data5 = 8'(8'h50 + acc);
         #2;
         if (s_ready5) begin
            chk("d5_AB", 32'(ab5), 32'(acc % 5));
            acc++;
         end
         if (!cena5) begin
            chk("d5_AA", 32'(aa5), 32'(rdn % 5));
            rdn++;
         end
         step();
      end
      s_valid5 = 1'b0;
      step();
      #2;
      chk("d5_accepted", 32'(acc), 32'd8);
      chk("d5_COUNT", 32'(count5), 32'd8);
      chk("d5_S_READY", 32'(s_ready5), 32'd0);
      step();
      m_ready5 = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (m_valid5) begin
            chk("d5_data", 32'(m_data5), 32'(8'h50 + got));
            got++;
         end
         if (!cena5) begin
            chk("d5_AA", 32'(aa5), 32'(rdn % 5));
            rdn++;
         end
         step();
      end
      chk("d5_words", 32'(got), 32'd8);
      chk("d5_reads", 32'(rdn), 32'd8);
      chk("d5_COUNT_end", 32'(count5), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
